// File: rtl/dsp_mac_pkg.sv
// Shared opmode field positions, X/Z select encodings and datapath widths
// for the DSP48A1-style multiply/accumulate stage.
package dsp_mac_pkg;

    localparam int A_W = 18;
    localparam int M_W = 36;
    localparam int P_W = 48;

    localparam int OPM_X          = 0;
    localparam int OPM_Z          = 2;
    localparam int OPM_PREADD_EN  = 4;
    localparam int OPM_PREADD_SUB = 6;
    localparam int OPM_POST_SUB   = 7;

    typedef enum logic [1:0] {
        X_ZERO = 2'b00,
        X_M    = 2'b01,
        X_P    = 2'b10,
        X_DAB  = 2'b11
    } xSel_e;

    typedef enum logic [1:0] {
        Z_ZERO = 2'b00,
        Z_PCIN = 2'b01,
        Z_P    = 2'b10,
        Z_C    = 2'b11
    } zSel_e;

    // Two's-complement overflow: operands effectively share a sign, result flips it
    function automatic logic signedOverflow(input logic zSign, input logic xSign,
                                            input logic sumSign, input logic isSub);
        logic sameSign;
        sameSign = isSub ? (zSign != xSign) : (zSign == xSign);
        return sameSign && (sumSign != zSign);
    endfunction

endpackage

// File: rtl/dsp_mac_stage_if.sv
// Operand/result bundle of the MAC stage; ovf exists only with DSP_MAC_OVF_EN.
interface dsp_mac_stage_if;
    import dsp_mac_pkg::*;

    logic             cem;
    logic             cep;
    logic [7:0]       opmode;
    logic [A_W-1:0]   a;
    logic [A_W-1:0]   b;
    logic [A_W-1:0]   d;
    logic [P_W-1:0]   c;
    logic             carryin;
    logic [P_W-1:0]   pcin;
    logic [A_W-1:0]   bcout;
    logic [M_W-1:0]   m;
    logic [P_W-1:0]   p;
    logic [P_W-1:0]   pcout;
    logic             carryout;
    logic             carryoutf;
`ifdef DSP_MAC_OVF_EN
    logic             ovf;
`endif

    modport slave (
        input  cem, cep, opmode, a, b, d, c, carryin, pcin,
        output bcout, m, p, pcout, carryout, carryoutf
`ifdef DSP_MAC_OVF_EN
        , output ovf
`endif
    );

    modport master (
        output cem, cep, opmode, a, b, d, c, carryin, pcin,
        input  bcout, m, p, pcout, carryout, carryoutf
`ifdef DSP_MAC_OVF_EN
        , input ovf
`endif
    );

endinterface

// File: rtl/dsp_pipe_reg.sv
// Optional pipeline register with clock enable and async clear; REG=0 is a wire.
module dsp_pipe_reg #(
    parameter int WIDTH = 1,
    parameter int REG   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        if (REG != 0) begin : gReg
            logic [WIDTH-1:0] data_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_q <= '0;
                end else if (ce_i) begin
                    data_q <= d_i;
                end
            end

            assign q_o = data_q;
        end else begin : gBypass
            assign q_o = d_i;
        end
    endgenerate

endmodule

// File: rtl/dsp_mac_stage.sv
// Pre-adder, 18x18 multiplier, X/Z muxes and 48-bit post-adder of the DSP slice.
// Define DSP_MAC_OVF_EN to add the sticky signed-overflow flag ovf.
module dsp_mac_stage
    import dsp_mac_pkg::*;
#(
    parameter int MREG        = 1,
    parameter int PREG        = 1,
    parameter int CARRYOUTREG = 1
) (
    input  logic            clk,
    input  logic            rst,
    dsp_mac_stage_if.slave  macBus
);

    logic [A_W-1:0]        preAdd;
    logic signed [M_W-1:0] preExt;
    logic signed [M_W-1:0] aExt;
    logic [M_W-1:0]        mProd;
    logic [M_W-1:0]        mOut;
    logic [P_W-1:0]        pOut;
    logic [P_W-1:0]        pFb;
    logic                  coOut;
    logic [P_W-1:0]        xMux;
    logic [P_W-1:0]        zMux;
    logic [P_W:0]          addend;
    logic [P_W:0]          sumFull;
    logic                  postSub;

    always_comb begin
        preAdd = macBus.b;
        if (macBus.opmode[OPM_PREADD_EN]) begin
            preAdd = macBus.opmode[OPM_PREADD_SUB] ? (macBus.d - macBus.b)
                                                   : (macBus.d + macBus.b);
        end
    end

    assign preExt = {{(M_W-A_W){preAdd[A_W-1]}}, preAdd};
    assign aExt   = {{(M_W-A_W){macBus.a[A_W-1]}}, macBus.a};
    assign mProd  = preExt * aExt;

    dsp_pipe_reg #(.WIDTH(M_W), .REG(MREG)) mReg (
        .clk  (clk),
        .rst  (rst),
        .ce_i (macBus.cem),
        .d_i  (mProd),
        .q_o  (mOut)
    );

    // Without a P register the feedback path would be a combinational loop
    generate
        if (PREG != 0) begin : gPFb
            assign pFb = pOut;
        end else begin : gPZero
            assign pFb = '0;
        end
    endgenerate

    always_comb begin
        xMux = '0;
        case (xSel_e'(macBus.opmode[OPM_X +: 2]))
            X_ZERO: xMux = '0;
            X_M:    xMux = {{(P_W-M_W){mOut[M_W-1]}}, mOut};
            X_P:    xMux = pFb;
            X_DAB:  xMux = {macBus.d[11:0], macBus.a, macBus.b};
        endcase
    end

    always_comb begin
        zMux = '0;
        case (zSel_e'(macBus.opmode[OPM_Z +: 2]))
            Z_ZERO: zMux = '0;
            Z_PCIN: zMux = macBus.pcin;
            Z_P:    zMux = pFb;
            Z_C:    zMux = macBus.c;
        endcase
    end

    assign postSub = macBus.opmode[OPM_POST_SUB];
    assign addend  = {1'b0, xMux} + {{P_W{1'b0}}, macBus.carryin};
    assign sumFull = postSub ? ({1'b0, zMux} - addend) : ({1'b0, zMux} + addend);

    dsp_pipe_reg #(.WIDTH(P_W), .REG(PREG)) pReg (
        .clk  (clk),
        .rst  (rst),
        .ce_i (macBus.cep),
        .d_i  (sumFull[P_W-1:0]),
        .q_o  (pOut)
    );

    dsp_pipe_reg #(.WIDTH(1), .REG(CARRYOUTREG)) coReg (
        .clk  (clk),
        .rst  (rst),
        .ce_i (macBus.cep),
        .d_i  (sumFull[P_W]),
        .q_o  (coOut)
    );

    assign macBus.bcout     = preAdd;
    assign macBus.m         = mOut;
    assign macBus.p         = pOut;
    assign macBus.pcout     = pOut;
    assign macBus.carryout  = coOut;
    assign macBus.carryoutf = coOut;

`ifdef DSP_MAC_OVF_EN
    logic ovf_q;
    logic ovf_d;

    // Sticky only while accumulating on P; any other Z source restarts it
    always_comb begin
        ovf_d = ovf_q;
        if (macBus.opmode[OPM_Z +: 2] != Z_P) begin
            ovf_d = 1'b0;
        end else if (signedOverflow(zMux[P_W-1], xMux[P_W-1], sumFull[P_W-1], postSub)) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (macBus.cep) begin
            ovf_q <= ovf_d;
        end
    end

    assign macBus.ovf = ovf_q;
`endif

endmodule
